// File: rtl/axi_rw_split_tracked.sv
// Splits one AXI4 slave port into a read master (AR/R) and a write master (AW/W/B), 0-cycle paths.
// Outstanding bursts are limited per direction; W waits for an issued AW. AXI_RW_SPLIT_AX_SPILL_EN adds an AR/AW spill stage (+1 cycle).
package axi_rw_split_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ax_chan_t;
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;
   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

`ifdef AXI_RW_SPLIT_AX_SPILL_EN
module axi_rw_split_spill #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);
   logic         a_full, b_full;
   logic [W-1:0] a_dat, b_dat;
   logic         a_fill, a_drain, b_fill, b_drain;

   assign in_rdy  = ~a_full | ~b_full;
   assign out_vld = a_full | b_full;
   assign out_dat = b_full ? b_dat : a_dat;
   assign a_fill  = in_vld & in_rdy;
   // A empties every cycle B is free: either straight out or parked in B.
   assign a_drain = a_full & ~b_full;
   assign b_fill  = a_drain & ~out_rdy;
   assign b_drain = b_full & out_rdy;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_full <= 1'b0;
         b_full <= 1'b0;
         a_dat  <= '0;
         b_dat  <= '0;
      end else begin
         if (a_fill) begin
            a_full <= 1'b1;
            a_dat  <= in_dat;
         end else if (a_drain) begin
            a_full <= 1'b0;
         end
         if (b_fill) begin
            b_full <= 1'b1;
            b_dat  <= a_dat;
         end else if (b_drain) begin
            b_full <= 1'b0;
         end
      end
   end
endmodule
`endif

module axi_rw_split_tracked #(
   parameter type         axi_req_t    = axi_rw_split_pkg::req_t,
   parameter type         axi_resp_t   = axi_rw_split_pkg::resp_t,
   parameter int unsigned MaxReadTxns  = 8,
   parameter int unsigned MaxWriteTxns = 8,
   localparam int unsigned RdCntW      = $clog2(MaxReadTxns + 1),
   localparam int unsigned WrCntW      = $clog2(MaxWriteTxns + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  axi_req_t          slv_req_i,
   output axi_resp_t         slv_resp_o,
   output axi_req_t          mst_read_req_o,
   input  axi_resp_t         mst_read_resp_i,
   output axi_req_t          mst_write_req_o,
   input  axi_resp_t         mst_write_resp_i,
   output logic [RdCntW-1:0] rd_outstanding_o,
   output logic [WrCntW-1:0] wr_outstanding_o,
   input  logic              clr_err_i,
   output logic              err_o
);
   localparam int unsigned ArW = $bits(slv_req_i.ar);
   localparam int unsigned AwW = $bits(slv_req_i.aw);
   localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxReadTxns);
   localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWriteTxns);
   localparam logic [RdCntW-1:0] RdOne = RdCntW'(1);
   localparam logic [WrCntW-1:0] WrOne = WrCntW'(1);

   logic [RdCntW-1:0] rd_cnt;
   logic [WrCntW-1:0] wr_cnt, w_cred;
   logic              err;
   logic              rd_room, wr_room, w_open;
   logic [ArW-1:0]    ar_dat;
   logic [AwW-1:0]    aw_dat;
   logic              ar_vld, ar_rdy, aw_vld, aw_rdy, slv_ar_rdy, slv_aw_rdy;
   logic              ar_go, aw_go, w_go, ar_hs, aw_hs, r_last_hs, b_hs, w_last_hs, err_set;
   logic              unused_bits;

   assign rd_room = (rd_cnt < RdMax) & ~rst_i;
   assign wr_room = (wr_cnt < WrMax) & ~rst_i;
   assign w_open  = (w_cred != '0) & ~rst_i;

`ifdef AXI_RW_SPLIT_AX_SPILL_EN
   logic ar_in_rdy, aw_in_rdy;
   axi_rw_split_spill #(.W(ArW)) u_ar_spill (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_vld(slv_req_i.ar_valid & ~rst_i), .in_rdy(ar_in_rdy), .in_dat(slv_req_i.ar),
      .out_vld(ar_vld), .out_rdy(ar_rdy), .out_dat(ar_dat)
   );
   axi_rw_split_spill #(.W(AwW)) u_aw_spill (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_vld(slv_req_i.aw_valid & ~rst_i), .in_rdy(aw_in_rdy), .in_dat(slv_req_i.aw),
      .out_vld(aw_vld), .out_rdy(aw_rdy), .out_dat(aw_dat)
   );
   assign slv_ar_rdy = ar_in_rdy & ~rst_i;
   assign slv_aw_rdy = aw_in_rdy & ~rst_i;
`else
   assign ar_dat     = slv_req_i.ar;
   assign ar_vld     = slv_req_i.ar_valid;
   assign aw_dat     = slv_req_i.aw;
   assign aw_vld     = slv_req_i.aw_valid;
   assign slv_ar_rdy = ar_rdy;
   assign slv_aw_rdy = aw_rdy;
`endif

   assign ar_go     = ar_vld & rd_room;
   assign ar_rdy    = mst_read_resp_i.ar_ready & rd_room;
   assign aw_go     = aw_vld & wr_room;
   assign aw_rdy    = mst_write_resp_i.aw_ready & wr_room;
   assign w_go      = slv_req_i.w_valid & w_open;
   assign ar_hs     = ar_go & mst_read_resp_i.ar_ready;
   assign aw_hs     = aw_go & mst_write_resp_i.aw_ready;
   assign w_last_hs = w_go & mst_write_resp_i.w_ready & slv_req_i.w.last;
   assign r_last_hs = mst_read_resp_i.r_valid & slv_req_i.r_ready & mst_read_resp_i.r.last;
   assign b_hs      = mst_write_resp_i.b_valid & slv_req_i.b_ready;
   assign err_set   = mst_read_resp_i.b_valid | mst_write_resp_i.r_valid
                    | (r_last_hs & (rd_cnt == '0)) | (b_hs & (wr_cnt == '0));

   always_comb begin
      mst_read_req_o          = '0;
      mst_read_req_o.ar       = ar_dat;
      mst_read_req_o.ar_valid = ar_go;
      mst_read_req_o.r_ready  = slv_req_i.r_ready;

      mst_write_req_o          = '0;
      mst_write_req_o.aw       = aw_dat;
      mst_write_req_o.aw_valid = aw_go;
      mst_write_req_o.w        = slv_req_i.w;
      mst_write_req_o.w_valid  = w_go;
      mst_write_req_o.b_ready  = slv_req_i.b_ready;

      slv_resp_o          = '0;
      slv_resp_o.ar_ready = slv_ar_rdy;
      slv_resp_o.aw_ready = slv_aw_rdy;
      slv_resp_o.w_ready  = mst_write_resp_i.w_ready & w_open;
      slv_resp_o.r        = mst_read_resp_i.r;
      slv_resp_o.r_valid  = mst_read_resp_i.r_valid;
      slv_resp_o.b        = mst_write_resp_i.b;
      slv_resp_o.b_valid  = mst_write_resp_i.b_valid;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
         w_cred <= '0;
         err    <= 1'b0;
      end else begin
         case ({ar_hs, r_last_hs})
            2'b10:   rd_cnt <= rd_cnt + RdOne;
            2'b01:   if (rd_cnt != '0) rd_cnt <= rd_cnt - RdOne;
            default: rd_cnt <= rd_cnt;
         endcase
         case ({aw_hs, b_hs})
            2'b10:   wr_cnt <= wr_cnt + WrOne;
            2'b01:   if (wr_cnt != '0) wr_cnt <= wr_cnt - WrOne;
            default: wr_cnt <= wr_cnt;
         endcase
         // A W-last handshake implies w_cred > 0, so only the increment needs a bound.
         case ({aw_hs, w_last_hs})
            2'b10:   if (w_cred != WrMax) w_cred <= w_cred + WrOne;
            2'b01:   w_cred <= w_cred - WrOne;
            default: w_cred <= w_cred;
         endcase
         if (err_set)        err <= 1'b1;
         else if (clr_err_i) err <= 1'b0;
      end
   end

   assign rd_outstanding_o = rd_cnt;
   assign wr_outstanding_o = wr_cnt;
   assign err_o            = err;

   assign unused_bits = ^{mst_read_resp_i.aw_ready, mst_read_resp_i.w_ready, mst_read_resp_i.b,
                          mst_write_resp_i.ar_ready, mst_write_resp_i.r};
endmodule
